// File: rtl/lsb_queue_pkg.sv
// Opcode encodings and shared constants for the load/store buffer.
// Loads occupy the low end of the opcode space, stores start at OPENUM_SB.
package lsb_queue_pkg;

   localparam int unsigned OPENUM_LB  = 1;
   localparam int unsigned OPENUM_LH  = 2;
   localparam int unsigned OPENUM_LW  = 3;
   localparam int unsigned OPENUM_LBU = 4;
   localparam int unsigned OPENUM_LHU = 5;
   localparam int unsigned OPENUM_SB  = 6;
   localparam int unsigned OPENUM_SH  = 7;
   localparam int unsigned OPENUM_SW  = 8;

   // ROB id 0 means "operand already available".
   localparam int unsigned ZERO_ROB = 0;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

endpackage

// File: rtl/lsb_operand_bypass.sv
// Combinational CDB tag match for one operand: zero latency, no backpressure.
// The lowest-numbered matching port wins; tag 0 never matches.
module lsb_operand_bypass
   import lsb_queue_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int ROB_W = 4,
   parameter int NCDB  = 2
) (
   input  logic [ROB_W-1:0]      q,
   input  logic [XLEN-1:0]       v,
   input  logic [NCDB-1:0]       cdb_valid,
   input  logic [NCDB*ROB_W-1:0] cdb_rob_id,
   input  logic [NCDB*XLEN-1:0]  cdb_result,
   output logic [ROB_W-1:0]      q_out,
   output logic [XLEN-1:0]       v_out
);

   localparam logic [ROB_W-1:0] ROB_NONE = ROB_W'(ZERO_ROB);

   // Walk ports from high to low so the lowest match overrides the rest.
   always_comb begin
      q_out = q;
      v_out = v;
      for (int k = NCDB - 1; k >= 0; k--) begin
         if (cdb_valid[k] && (q != ROB_NONE) && (cdb_rob_id[k*ROB_W +: ROB_W] == q)) begin
            q_out = ROB_NONE;
            v_out = cdb_result[k*XLEN +: XLEN];
         end
      end
   end

endmodule

// File: rtl/lsb_queue.sv
// In-order load/store buffer: issue registered one edge after the head becomes eligible.
// ex_busy holds the head in place; full asserts with one slot left for an in-flight dispatch.
module lsb_queue
   import lsb_queue_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int XLEN  = 32,
   parameter int ROB_W = 4,
   parameter int OP_W  = 6,
   parameter int NCDB  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  dsp_valid,
   input  logic [OP_W-1:0]       dsp_openum,
   input  logic [XLEN-1:0]       dsp_v1,
   input  logic [XLEN-1:0]       dsp_v2,
   input  logic [ROB_W-1:0]      dsp_q1,
   input  logic [ROB_W-1:0]      dsp_q2,
   input  logic [XLEN-1:0]       dsp_imm,
   input  logic [ROB_W-1:0]      dsp_rob_id,
   output logic                  full,
   input  logic                  ex_busy,
   output logic                  ex_valid,
   output logic [OP_W-1:0]       ex_openum,
   output logic [XLEN-1:0]       ex_addr,
   output logic [XLEN-1:0]       ex_store_value,
   output logic [ROB_W-1:0]      ex_rob_id,
   input  logic [NCDB-1:0]       cdb_valid,
   input  logic [NCDB*ROB_W-1:0] cdb_rob_id,
   input  logic [NCDB*XLEN-1:0]  cdb_result,
   input  logic                  commit_valid,
   input  logic [ROB_W-1:0]      commit_rob_id,
   output logic                  store_ready_valid,
   output logic [ROB_W-1:0]      store_ready_rob_id,
   input  logic                  rollback
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [OP_W-1:0]  OP_LHU   = OP_W'(OPENUM_LHU);
   localparam logic [OP_W-1:0]  OP_SB    = OP_W'(OPENUM_SB);
   localparam logic [ROB_W-1:0] ROB_NONE = ROB_W'(ZERO_ROB);

   typedef struct packed {
      logic             valid;
      logic             committed;
      logic [OP_W-1:0]  op;
      logic [ROB_W-1:0] q1;
      logic [ROB_W-1:0] q2;
      logic [XLEN-1:0]  v1;
      logic [XLEN-1:0]  v2;
      logic [XLEN-1:0]  imm;
      logic [ROB_W-1:0] rob_id;
   } entry_t;

   entry_t           ent [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [CW-1:0]    count;
   logic [CW-1:0]    ccount;
   logic             notified;

   logic [ROB_W-1:0] wq1 [DEPTH];
   logic [ROB_W-1:0] wq2 [DEPTH];
   logic [XLEN-1:0]  wv1 [DEPTH];
   logic [XLEN-1:0]  wv2 [DEPTH];
   logic [ROB_W-1:0] dq1, dq2;
   logic [XLEN-1:0]  dv1, dv2;

   entry_t           hd;
   entry_t           ins_ent;
   logic             hd_load, hd_store, hd_ready;
   logic             do_issue, do_notify, do_insert, iss_store, cmt_any;
   logic [DEPTH-1:0] cmt_hit;
   logic [DEPTH-1:0] keep;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [CW-1:0] n);
      logic [CW:0] s;
      s = {{(CW + 1 - PW){1'b0}}, p} + {1'b0, n};
      if (s >= (CW + 1)'(DEPTH))
         s = s - (CW + 1)'(DEPTH);
      return s[PW-1:0];
   endfunction

   lsb_operand_bypass #(.XLEN(XLEN), .ROB_W(ROB_W), .NCDB(NCDB)) u_dsp_b1 (
      .q(dsp_q1), .v(dsp_v1), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
      .cdb_result(cdb_result), .q_out(dq1), .v_out(dv1)
   );

   lsb_operand_bypass #(.XLEN(XLEN), .ROB_W(ROB_W), .NCDB(NCDB)) u_dsp_b2 (
      .q(dsp_q2), .v(dsp_v2), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
      .cdb_result(cdb_result), .q_out(dq2), .v_out(dv2)
   );

   for (genvar i = 0; i < DEPTH; i++) begin : g_wake
      lsb_operand_bypass #(.XLEN(XLEN), .ROB_W(ROB_W), .NCDB(NCDB)) u_b1 (
         .q(ent[i].q1), .v(ent[i].v1), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
         .cdb_result(cdb_result), .q_out(wq1[i]), .v_out(wv1[i])
      );
      lsb_operand_bypass #(.XLEN(XLEN), .ROB_W(ROB_W), .NCDB(NCDB)) u_b2 (
         .q(ent[i].q2), .v(ent[i].v2), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
         .cdb_result(cdb_result), .q_out(wq2[i]), .v_out(wv2[i])
      );
   end

   assign full = (count >= CW'(DEPTH - 1));

   assign hd        = ent[head];
   assign hd_load   = (hd.op <= OP_LHU);
   assign hd_store  = (hd.op >= OP_SB);
   assign hd_ready  = hd.valid && (hd.q1 == ROB_NONE) && (hd.q2 == ROB_NONE);
   assign do_issue  = rdy && !rollback && hd_ready && !ex_busy &&
                      (hd_load || (hd_store && hd.committed));
   assign do_notify = rdy && !rollback && hd_ready && hd_store && !hd.committed && !notified;
   assign do_insert = rdy && !rollback && dsp_valid;
   assign iss_store = do_issue && hd_store;
   assign cmt_any   = commit_valid && (|cmt_hit);

   always_comb begin
      ins_ent           = '0;
      ins_ent.valid     = TRUE;
      ins_ent.committed = FALSE;
      ins_ent.op        = dsp_openum;
      ins_ent.q1        = dq1;
      ins_ent.q2        = dq2;
      ins_ent.v1        = dv1;
      ins_ent.v2        = dv2;
      ins_ent.imm       = dsp_imm;
      ins_ent.rob_id    = dsp_rob_id;
   end

   // Already-committed entries are excluded so a repeated commit cannot bump ccount twice.
   always_comb begin
      cmt_hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cmt_hit[i] = ent[i].valid && !ent[i].committed && (ent[i].op >= OP_SB) &&
                      (ent[i].rob_id == commit_rob_id);
      end
   end

   // An entry survives rollback when its distance from head is below ccount.
   always_comb begin
      keep = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i >= int'(head))
            keep[i] = (i - int'(head)) < int'(ccount);
         else
            keep[i] = (i + DEPTH - int'(head)) < int'(ccount);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            ent[i] <= '0;
         head               <= '0;
         tail               <= '0;
         count              <= '0;
         ccount             <= '0;
         notified           <= FALSE;
         ex_valid           <= FALSE;
         ex_openum          <= '0;
         ex_addr            <= '0;
         ex_store_value     <= '0;
         ex_rob_id          <= '0;
         store_ready_valid  <= FALSE;
         store_ready_rob_id <= '0;
      end else if (!rdy) begin
         ex_valid          <= FALSE;
         store_ready_valid <= FALSE;
      end else if (rollback) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!keep[i])
               ent[i] <= '0;
         end
         tail              <= ptr_add(head, ccount);
         count             <= ccount;
         notified          <= FALSE;
         ex_valid          <= FALSE;
         store_ready_valid <= FALSE;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ent[i].valid) begin
               ent[i].q1 <= wq1[i];
               ent[i].v1 <= wv1[i];
               ent[i].q2 <= wq2[i];
               ent[i].v2 <= wv2[i];
            end
            if (commit_valid && cmt_hit[i])
               ent[i].committed <= TRUE;
         end

         if (do_issue) begin
            ent[head].valid     <= FALSE;
            ent[head].committed <= FALSE;
            head                <= ptr_inc(head);
            notified            <= FALSE;
         end else if (do_notify) begin
            notified <= TRUE;
         end

         if (do_insert) begin
            ent[tail] <= ins_ent;
            tail      <= ptr_inc(tail);
         end

         count  <= count + CW'(do_insert) - CW'(do_issue);
         ccount <= ccount + CW'(cmt_any) - CW'(iss_store);

         ex_valid <= do_issue;
         if (do_issue) begin
            ex_openum      <= hd.op;
            ex_addr        <= hd.v1 + hd.imm;
            ex_store_value <= hd.v2;
            ex_rob_id      <= hd.rob_id;
         end

         store_ready_valid <= do_notify;
         if (do_notify)
            store_ready_rob_id <= hd.rob_id;
      end
   end

   // The dispatcher must honour full; a dispatch into a completely full queue is lost.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(rdy && dsp_valid && (count == CW'(DEPTH))));

endmodule
